// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display controller:
// glyph codes, segment patterns and the scan FSM state encoding.
package display_pkg;

  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational 5-bit glyph code to active-low {g,f,e,d,c,b,a} decoder.
// One instance is shared by every digit position of the scanner.
module seg7_glyph_dec
  import display_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  // Hex glyphs, a dash, everything else dark.
  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      5'h00:     o_seg = 7'h40;
      5'h01:     o_seg = 7'h79;
      5'h02:     o_seg = 7'h24;
      5'h03:     o_seg = 7'h30;
      5'h04:     o_seg = 7'h19;
      5'h05:     o_seg = 7'h12;
      5'h06:     o_seg = 7'h02;
      5'h07:     o_seg = 7'h78;
      5'h08:     o_seg = 7'h00;
      5'h09:     o_seg = 7'h10;
      5'h0A:     o_seg = 7'h08;
      5'h0B:     o_seg = 7'h03;
      5'h0C:     o_seg = 7'h46;
      5'h0D:     o_seg = 7'h21;
      5'h0E:     o_seg = 7'h06;
      5'h0F:     o_seg = 7'h0E;
      CODE_DASH: o_seg = SEG_DASH;
      default:   o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with a shared decoder.
// Define DISPLAY_SCAN_BLANK_EN to add a dark BLANK gap at each slot end.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [4:0]                    wr_code,
  output logic [6:0]                    seg_n,
  output logic [NUM_DIGITS-1:0]         dig_n,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_tick
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);

`ifdef DISPLAY_SCAN_BLANK_EN
  localparam int SHOW_LEN = PRESCALE - BLANK_CYCLES;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`else
  localparam int SHOW_LEN = PRESCALE;
`endif

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_LEN - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_DIGITS - 1);
  localparam logic [AW:0]   NUM_D     = (AW+1)'(NUM_DIGITS);

  if (NUM_DIGITS < 2 || PRESCALE < 4 ||
      BLANK_CYCLES < 1 || BLANK_CYCLES > PRESCALE - 2) begin : g_param_err
    $error("display_scan_ctrl: parameter out of range");
  end

  logic [4:0]            r_code [NUM_DIGITS];
  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_idx;
  logic                  r_wrap;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic [AW-1:0]         r_scan;
  logic                  r_tick;

  logic                  w_addr_ok;
  logic [4:0]            w_code;
  logic [6:0]            w_seg;
  logic [AW-1:0]         w_idx_next;
  logic                  w_idx_wrap;
  logic [NUM_DIGITS-1:0] w_dig_sel;

  assign w_addr_ok  = {1'b0, wr_addr} < NUM_D;
  assign w_code     = r_code[r_idx];
  assign w_idx_wrap = (r_idx == LAST_IDX);
  assign w_idx_next = w_idx_wrap ? '0 : r_idx + 1'b1;
  assign w_dig_sel  = ~(NUM_DIGITS'(1) << r_idx);

  seg7_glyph_dec u_dec (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Code register file; writes land on the same edge they are sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_code[i] <= CODE_BLANK;
    end else if (wr_en && w_addr_ok) begin
      r_code[wr_addr] <= wr_code;
    end
  end

  // Scan FSM: slot counter, digit index and wrap flag.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SHOW;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            r_cnt <= '0;
`ifdef DISPLAY_SCAN_BLANK_EN
            r_state <= ST_BLANK;
`else
            r_idx  <= w_idx_next;
            r_wrap <= w_idx_wrap;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef DISPLAY_SCAN_BLANK_EN
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_SHOW;
            r_idx   <= w_idx_next;
            r_wrap  <= w_idx_wrap;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Output registers; digit select and segments move on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_seg  <= SEG_OFF;
      r_dig  <= '1;
      r_scan <= '0;
      r_tick <= 1'b0;
    end else begin
      r_scan <= r_idx;
      r_tick <= r_wrap;
      if (r_state == ST_SHOW) begin
        r_seg <= w_seg;
        r_dig <= w_dig_sel;
      end else begin
        r_seg <= SEG_OFF;
        r_dig <= '1;
      end
    end
  end

  assign seg_n      = r_seg;
  assign dig_n      = r_dig;
  assign scan_idx   = r_scan;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (N=4, PRESCALE=8, BLANK=2).
// Expected outputs come from a time-since-enable slot model.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
`ifdef DISPLAY_SCAN_BLANK_EN
  localparam int SHOW = P - B;
`else
  localparam int SHOW = P;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [4:0] wr_code = '0;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  logic [1:0] scan_idx;
  logic       frame_tick;

  int n_chk = 0;
  int n_fail = 0;
  int age = 0;
  logic [4:0] mcode [N];

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_code    (wr_code),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] ref_glyph(input logic [4:0] c);
    logic [6:0] hex [16];
    hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (c < 5'h10) return hex[c[3:0]];
    if (c == 5'h11) return 7'h3F;
    return 7'h7F;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare against the slot model, then retire the write.
  task automatic step();
    int t;
    int slot;
    int pos;
    int dig;
    logic [6:0] es;
    logic [3:0] ed;
    logic [1:0] ei;
    logic       et;
    @(posedge clk);
    #2;
    if (rst_n && enable) age++;
    else age = 0;
    es = 7'h7F;
    ed = 4'hF;
    ei = 2'd0;
    et = 1'b0;
    if (age >= 2) begin
      t    = age - 2;
      slot = t / P;
      pos  = t % P;
      dig  = slot % N;
      ei   = dig[1:0];
      et   = (pos == 0) && (slot > 0) && (dig == 0);
      if (pos < SHOW) begin
        ed = ~(4'b0001 << dig);
        es = ref_glyph(mcode[dig]);
      end
    end
    chk("seg_n", {1'b0, seg_n}, {1'b0, es});
    chk("dig_n", {4'h0, dig_n}, {4'h0, ed});
    chk("scan_idx", {6'h0, scan_idx}, {6'h0, ei});
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, et});
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mcode[i] = 5'h10;
    end else if (wr_en) begin
      mcode[wr_addr] = wr_code;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_slot(input int d, input int p);
    int n;
    n = 0;
    while (!(age >= 2 && ((age - 2) % P) == p &&
             (((age - 2) / P) % N) == d)) begin
      step();
      n++;
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_slot: digit %0d pos %0d not reached", d, p);
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mcode[i] = 5'h10;

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      wr_addr = 2'(i);
      wr_code = 5'(i + 1);
      step();
    end
    enable = 1'b1;
    repeat (2 * N * P + 4) step();

    wait_slot(2, 1);
    wr_en   = 1'b1;
    wr_addr = 2'd2;
    wr_code = 5'h11;
    step();
    step();
    chk("live_dash", {1'b0, seg_n}, 8'h3F);
    repeat (20) step();

    wait_slot(1, 2);
    enable = 1'b0;
    step();
    chk("disable_dark", {4'h0, dig_n}, 8'h0F);
    repeat (3) step();
    enable = 1'b1;
    repeat (N * P + 4) step();

    wait_slot(3, 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (N * P + 4) step();

    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 2'($urandom_range(0, N - 1));
        wr_code = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
